// File: rtl/mem_router_if.sv
// Core-side and memory-side bus of the memory router.
// The slave modport is the router's view; the master modport is the view of the core and the regions.
interface mem_router_if #(
  parameter int unsigned AW   = 20,
  parameter int unsigned NREG = 3
);
  logic              req;
  logic [AW-1:0]     address;
  logic              we;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ready;
  logic              buserr;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic [NREG-1:0]   mem_we;
  logic [NREG-1:0]   mem_rd;
  logic [NREG*8-1:0] mem_q;

  modport slave (
    input  req, address, we, wdata, mem_q,
    output rdata, ready, buserr, mem_addr, mem_wdata, mem_we, mem_rd
  );

  modport master (
    output req, address, we, wdata, mem_q,
    input  rdata, ready, buserr, mem_addr, mem_wdata, mem_we, mem_rd
  );
endinterface

// File: rtl/mem_router.sv
// Sequential router from the core bus to NREG memory regions.
// Each region has its own base/mask decode and its own read latency.
module mem_router #(
  parameter int unsigned           AW   = 20,
  parameter int unsigned           NREG = 3,
  parameter logic [NREG*AW-1:0]    BASE = {20'hFE000, 20'hB8000, 20'h00000},
  parameter logic [NREG*AW-1:0]    MASK = {20'hFE000, 20'hFC000, 20'hFC000},
  parameter logic [NREG*4-1:0]     WAIT = {4'd1, 4'd1, 4'd1}
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_router_if.slave bus
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] UNMAP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            wr_q, wr_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            buserr_q, buserr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [NREG-1:0] we_q, we_d;
  logic [NREG-1:0] rd_q, rd_d;

  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [NREG-1:0] hit_onehot;

  // Scan from the top index down so the lowest matching region is the last one written.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((bus.address & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    if (hit) begin
      hit_onehot[hit_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    buserr_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = '0;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.address;
          wdata_d = bus.wdata;
          sel_d   = hit_idx;
          wr_d    = bus.we;
          if (!hit) begin
            state_d = UNMAP;
          end else begin
            state_d = ACCESS;
            if (bus.we) begin
              we_d = hit_onehot;
            end else begin
              rd_d  = hit_onehot;
              cnt_d = WAIT[4*hit_idx +: 4];
            end
          end
        end
      end
      ACCESS: begin
        if (wr_q) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = bus.mem_q[8*sel_q +: 8];
          rd_d    = '0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      UNMAP: begin
        ready_d  = 1'b1;
        buserr_d = 1'b1;
        rdata_d  = 8'hFF;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= 8'hFF;
      ready_q  <= 1'b0;
      buserr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      we_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      buserr_q <= buserr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.buserr    = buserr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_rd    = rd_q;

endmodule
